// File: rtl/parallel_load.sv
// ---------------------------------------------------------------------------
// parallel_load
//
// WIDTH-bit parallel-in / parallel-out register. Every rising clock edge the
// whole input word is captured as-is. There is no enable, so the value is
// held only as long as din is held. A synchronous, active-high reset forces
// the stored word to RESET_VALUE and wins over the load on the same edge.
//
// Parameters
//   WIDTH        data width of din and qout (1 or greater)
//   RESET_VALUE  word loaded into qout while reset is high at a clock edge
//
// Ports
//   clk    in   1      single clock, all updates on its rising edge
//   reset  in   1      synchronous active-high reset
//   din    in   WIDTH  parallel data captured every edge
//   qout   out  WIDTH  stored word, driven straight from the flops
// ---------------------------------------------------------------------------
module parallel_load #(
   parameter int                WIDTH       = 4,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  qout
);

   // Storage flops. qout is a plain copy of these, so no din-to-qout path exists.
   logic [WIDTH-1:0] qout_r;

   // Capture din every edge; reset takes priority over the load.
   always_ff @(posedge clk) begin
      if (reset) begin
         qout_r <= RESET_VALUE;
      end else begin
         qout_r <= din;
      end
   end

   assign qout = qout_r;

endmodule

// File: tb/tb_parallel_load.sv
// ---------------------------------------------------------------------------
// tb_parallel_load
//
// Self-checking bench for parallel_load. Two instances are exercised in
// lock-step: the default 4-bit one with a zero reset word, and an 8-bit one
// with a non-zero reset word. The expected register contents are worked out
// from the behaviour rules: after an edge, qout is RESET_VALUE if reset was
// high at that edge, otherwise the din value present at that edge. Between
// edges qout must not move, even while din and reset glitch.
// ---------------------------------------------------------------------------
module tb_parallel_load;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  din;
   logic [3:0]  qout;
   logic [7:0]  din8;
   logic [7:0]  qout8;

   int          checks   = 0;
   int          failures = 0;

   // expected contents of each register after the most recent edge
   logic [3:0]  exp4;
   logic [7:0]  exp8;

   localparam logic [7:0] RV8 = 8'hA5;

   // 10-unit period, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   parallel_load dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .qout  (qout)
   );

   parallel_load #(
      .WIDTH       (8),
      .RESET_VALUE (RV8)
   ) dut8 (
      .clk   (clk),
      .reset (reset),
      .din   (din8),
      .qout  (qout8)
   );

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] req);
      checks++;
      if (obs !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, req, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, optionally glitch din/reset
   // away from their final values first, then check after the rising edge.
   task automatic step(input logic r, input logic [3:0] d, input logic [7:0] d8,
                       input bit glitch, input string tag);
      @(negedge clk);
      if (glitch) begin
         reset = ~r;
         din   = ~d;
         din8  = ~d8;
         #1;
         check_eq({tag, "_hold4"}, {4'h0, qout}, {4'h0, exp4});
         check_eq({tag, "_hold8"}, qout8, exp8);
         #1;
      end
      reset = r;
      din   = d;
      din8  = d8;
      @(posedge clk);
      #1;
      exp4 = r ? 4'h0 : d;
      exp8 = r ? RV8 : d8;
      check_eq({tag, "_q4"}, {4'h0, qout}, {4'h0, exp4});
      check_eq({tag, "_q8"}, qout8, exp8);
   endtask

   initial begin
      logic       r;
      logic [3:0] d;
      logic [7:0] d8;
      bit         g;

      // reset at the first edge
      reset = 1'b1;
      din   = 4'b0000;
      din8  = 8'h3C;
      @(posedge clk);
      #1;
      exp4 = 4'h0;
      exp8 = RV8;
      check_eq("rst_q4", {4'h0, qout}, 8'h00);
      check_eq("rst_q8", qout8, RV8);

      // basic loads
      step(1'b0, 4'b1010, 8'h5A, 1'b0, "load_1010");
      step(1'b0, 4'b0011, 8'hC3, 1'b0, "load_0011");
      step(1'b0, 4'b1111, 8'hFF, 1'b0, "load_1111");
      // din and reset toggle between edges, settle at 1111 / 0
      step(1'b0, 4'b1111, 8'hFF, 1'b1, "glitch_1111");
      step(1'b0, 4'b0101, 8'h96, 1'b0, "load_0101");
      // hold with constant din
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'b0101, 8'h96, 1'b0, "hold_0101");
      end
      // reset mid-operation, then immediate recovery
      step(1'b0, 4'b1010, 8'h11, 1'b0, "pre_rst");
      step(1'b1, 4'b1111, 8'hEE, 1'b0, "rst_pri");
      step(1'b0, 4'b1111, 8'hEE, 1'b0, "rst_recover");
      // reset pulsed between edges only
      step(1'b0, 4'b1111, 8'hEE, 1'b1, "rst_pulse");
      // reset held for several edges
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'b0110, 8'h77, 1'b0, "rst_held");
      end
      step(1'b0, 4'b1001, 8'h81, 1'b0, "after_held");

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 7) == 0);
         d  = 4'($urandom);
         d8 = 8'($urandom);
         g  = ($urandom_range(0, 3) == 0);
         step(r, d, d8, g, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parallel_load.md
PARALLEL_LOAD -- requirements
Module: parallel_load

Interface
REQ-001 Parameter: WIDTH, default 4, data width of din and qout in bits; legal range 1 or greater.
REQ-002 Parameter: RESET_VALUE, default 0 (WIDTH bits), value loaded into qout by reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 Port: din  input  WIDTH  parallel data to load.
REQ-006 Port: qout  output  WIDTH  registered parallel output; driven directly from storage flops.
REQ-007 The design SHALL use one clock (clk), with reset synchronous and active-high.

Function
REQ-008 The block SHALL be a WIDTH-bit parallel-in/parallel-out register, loading unconditionally every cycle.
REQ-009 At each rising clk edge with reset=0, qout SHALL take the value of din sampled at that edge.
REQ-010 Load latency SHALL be exactly one clock: din at edge N appears on qout after edge N and holds until edge N+1.
REQ-011 qout SHALL change only on rising clk edges; din changes between edges SHALL NOT affect qout (no combinational din-to-qout path).
REQ-012 All WIDTH bits SHALL load in the same edge; there is no shifting, masking, or bit reordering (qout[i] = din[i]).
REQ-013 din changing coincident with the clock edge SHALL be treated as the pre-edge value (standard setup/hold semantics).
REQ-014 There is no enable; holding a value requires holding din constant.
REQ-015 Before the first rising edge with reset=1, qout SHALL be unspecified; no power-on value is required.

Reset
REQ-016 At a rising clk edge with reset=1, qout SHALL become RESET_VALUE (default 4'b0000), regardless of din.
REQ-017 Reset SHALL take priority over load in the same edge.
REQ-018 Asserting reset between clock edges SHALL NOT change qout until the next rising edge (synchronous only).
REQ-019 Reset asserted mid-operation SHALL clear qout at the next edge; loading SHALL resume at the first edge where reset=0, with no extra recovery cycle.
REQ-020 Reset held for multiple cycles SHALL keep qout at RESET_VALUE for each of those edges.

Verification
REQ-021 With 10-unit clock period (rising edges at 5, 15, 25, ...): reset=1 and din=0000 at t=0, rising edge at t=5 -> qout=0000.
REQ-022 reset=0 and din=1010 at t=10, rising edge at t=15 -> qout=1010; then din=0011 at t=20, rising edge at t=25 -> qout=0011.
REQ-023 din=1111 at t=30, rising edge at t=35 -> qout=1111; din=0101 at t=40, rising edge at t=45 -> qout=0101, held through t=145 with din constant.
REQ-024 With qout=1111, toggle din between edges (1111->0000->1111) and hold 1111 at the edge -> qout stays 1111, with no glitch.
REQ-025 With qout=1010, assert reset=1 with din=1111 for one edge -> qout=0000; deassert reset -> next edge qout=1111.
REQ-026 With reset=1 pulsed between edges only (not high at any rising edge) -> qout unchanged.
